// File: rtl/psum_drain_module.sv
// rtl/psum_drain_module.sv - MAC window accumulator feeding a partial-sum output FIFO
module psum_drain_module #(
  parameter int IF_CELL_SIZE     = 8,
  parameter int FILTER_CELL_SIZE = 8,
  parameter int PSUM_WIDTH       = 16,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inner_start,
  input  logic                        mult_valid,
  input  logic [IF_CELL_SIZE-1:0]     if_data,
  input  logic [FILTER_CELL_SIZE-1:0] filter_data,
  input  logic                        par_done,
  input  logic                        done_in,
  input  logic                        out_ren,
  output logic [PSUM_WIDTH-1:0]       out_dout,
  output logic                        out_empty,
  output logic                        out_full,
  output logic                        stall,
  output logic                        all_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_FULL} state_t;

  state_t                state, next_state;
  logic [PSUM_WIDTH-1:0] acc, hold, prod, sum, push_data;
  logic [PSUM_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  done_seen, full;
  logic                  push, pop, acc_add, acc_clear, hold_load;

  assign prod      = PSUM_WIDTH'(if_data) * PSUM_WIDTH'(filter_data);
  assign sum       = acc + (mult_valid ? prod : '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_ren && (count != '0);
  assign out_empty = (count == '0);
  assign out_full  = full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (inner_start) begin
      next_state = ACCUM;
    end else begin
      case (state)
        ACCUM:     if (par_done && full) next_state = WAIT_FULL;
        WAIT_FULL: if (!full)            next_state = ACCUM;
        default:   next_state = state;
      endcase
    end
  end

  // Push decisions use the registered count, so a same-cycle pop never admits a push.
  always_comb begin
    push      = 1'b0;
    push_data = sum;
    acc_add   = 1'b0;
    acc_clear = 1'b0;
    hold_load = 1'b0;
    if (!inner_start) begin
      case (state)
        ACCUM: begin
          if (par_done) begin
            acc_clear = 1'b1;
            if (!full) push = 1'b1;
            else       hold_load = 1'b1;
          end else if (mult_valid) begin
            acc_add = 1'b1;
          end
        end
        WAIT_FULL: begin
          if (!full) begin
            push      = 1'b1;
            push_data = hold;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      hold      <= '0;
      stall     <= 1'b0;
      done_seen <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      if (inner_start || acc_clear) acc <= '0;
      else if (acc_add)             acc <= sum;

      if (hold_load) hold <= sum;

      if (inner_start)                     stall <= 1'b0;
      else if (hold_load)                  stall <= 1'b1;
      else if (state == WAIT_FULL && push) stall <= 1'b0;

      if (inner_start)                        done_seen <= 1'b0;
      else if (state == ACCUM && done_in)     done_seen <= 1'b1;

      if (inner_start)
        all_done <= 1'b0;
      else if (done_seen && state == ACCUM && count == '0 && !push)
        all_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_dout <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        out_dout <= mem[rd_ptr];
        rd_ptr   <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
